// File: rtl/v4_op_centric_queue_if.sv
// Bus bundle for v4_op_centric_queue: level requests and operands from the
// issue side (master), one-cycle completion pulses, results and occupancy
// from the queue (slave).
// Optional macro: V4_OCQ_PEEK_EN adds peek_tag_in / peek_valid / peek_data.
interface v4_op_centric_queue_if #(
    parameter int p_depth     = 8,
    parameter int p_ptrwidth  = $clog2(p_depth),
    parameter int p_chanwidth = 32
);
    logic                         enq_back_req, enq_front_req, deq_front_req;
    logic                         deq_back_req, upd_req, del_req;
    logic                         enq_back_cpl, enq_front_cpl, deq_front_cpl;
    logic                         deq_back_cpl, upd_cpl, del_cpl;
    logic [p_chanwidth-1:0]       enq_back_data, enq_front_data;
    logic [p_ptrwidth-1:0]        enq_back_tag_out, enq_front_tag_out;
    logic [p_chanwidth-1:0]       deq_front_data, deq_back_data;
    logic [p_ptrwidth-1:0]        upd_tag_in, del_tag_in;
    logic [p_chanwidth-1:0]       upd_data_in;
    logic                         err;
    logic [$clog2(p_depth+1)-1:0] count;
    logic                         full, empty;
`ifdef V4_OCQ_PEEK_EN
    logic [p_ptrwidth-1:0]        peek_tag_in;
    logic                         peek_valid;
    logic [p_chanwidth-1:0]       peek_data;
`endif

    modport master (
        output enq_back_req, enq_front_req, deq_front_req, deq_back_req,
               upd_req, del_req, enq_back_data, enq_front_data,
               upd_tag_in, del_tag_in, upd_data_in,
`ifdef V4_OCQ_PEEK_EN
        output peek_tag_in,
        input  peek_valid, peek_data,
`endif
        input  enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl,
               upd_cpl, del_cpl, enq_back_tag_out, enq_front_tag_out,
               deq_front_data, deq_back_data, err, count, full, empty
    );

    modport slave (
        input  enq_back_req, enq_front_req, deq_front_req, deq_back_req,
               upd_req, del_req, enq_back_data, enq_front_data,
               upd_tag_in, del_tag_in, upd_data_in,
`ifdef V4_OCQ_PEEK_EN
        input  peek_tag_in,
        output peek_valid, peek_data,
`endif
        output enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl,
               upd_cpl, del_cpl, enq_back_tag_out, enq_front_tag_out,
               deq_front_data, deq_back_data, err, count, full, empty
    );
endinterface

// File: rtl/v4_op_centric_queue.sv
// Tag-addressed double-ended queue. Entries live in a positional array
// (position 0 = front); each holds {tag, data}. Enqueues allocate the lowest
// free tag, which stays attached to the entry until it is dequeued/deleted.
// One operation at a time: accept (IDLE) -> apply (EXEC) -> complete (DONE).
// Ports: clk, rst (sync, active-high), bus (v4_op_centric_queue_if.slave):
//   six level reqs with operands, six cpl pulses, err, tag outs, deq data,
//   count / full / empty.
// Optional macro: V4_OCQ_PEEK_EN builds a combinational peek-by-tag port.
//
// state | meaning
// IDLE  | waiting; highest-priority pending req and its operands are latched
// EXEC  | latched op checked and applied to storage, results registered
// DONE  | cpl and err presented for one cycle
module v4_op_centric_queue #(
    parameter int p_depth     = 8,
    parameter int p_ptrwidth  = $clog2(p_depth),
    parameter int p_chanwidth = 32
) (
    input logic                  clk,
    input logic                  rst,
    v4_op_centric_queue_if.slave bus
);
    localparam int cw = $clog2(p_depth + 1);
    localparam int tw = 2 ** p_ptrwidth;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_DEL = 3'd0;
    localparam logic [2:0] OP_UPD = 3'd1;
    localparam logic [2:0] OP_DQF = 3'd2;
    localparam logic [2:0] OP_DQB = 3'd3;
    localparam logic [2:0] OP_ENF = 3'd4;
    localparam logic [2:0] OP_ENB = 3'd5;

    logic [1:0]             state;
    logic [2:0]             op;
    logic [p_chanwidth-1:0] op_data;
    logic [p_ptrwidth-1:0]  op_tag;
    logic [p_ptrwidth-1:0]  tag_mem  [p_depth];
    logic [p_chanwidth-1:0] data_mem [p_depth];
    logic [p_depth-1:0]     alloc;
    logic [tw-1:0]          alloc_pad;
    logic [cw-1:0]          count;
    logic [5:0]             cpl;
    logic                   err_r;
    logic [p_ptrwidth-1:0]  tag_b, tag_f;
    logic [p_chanwidth-1:0] dqf_data, dqb_data;
    logic [p_ptrwidth-1:0]  free_tag, match_pos;
    logic                   is_full, is_empty, op_err;

    // Padding the mask out to every encodable tag makes out-of-range tags
    // read as unallocated without a separate range compare.
    assign alloc_pad = tw'(alloc);
    assign is_full   = (count == cw'(p_depth));
    assign is_empty  = (count == '0);

    always_comb begin
        free_tag = '0;
        for (int i = p_depth - 1; i >= 0; i--)
            if (!alloc[i]) free_tag = p_ptrwidth'(i);
    end

    always_comb begin
        match_pos = '0;
        for (int i = 0; i < p_depth; i++)
            if (i < int'(count) && tag_mem[i] == op_tag) match_pos = p_ptrwidth'(i);
    end

    always_comb begin
        op_err = 1'b0;
        case (op)
            OP_ENB, OP_ENF: op_err = is_full;
            OP_DQF, OP_DQB: op_err = is_empty;
            default:        op_err = !alloc_pad[op_tag];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op       <= OP_DEL;
            op_data  <= '0;
            op_tag   <= '0;
            alloc    <= '0;
            count    <= '0;
            cpl      <= '0;
            err_r    <= 1'b0;
            tag_b    <= '0;
            tag_f    <= '0;
            dqf_data <= '0;
            dqb_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_EXEC;
                    if (bus.del_req) begin
                        op     <= OP_DEL;
                        op_tag <= bus.del_tag_in;
                    end else if (bus.upd_req) begin
                        op      <= OP_UPD;
                        op_tag  <= bus.upd_tag_in;
                        op_data <= bus.upd_data_in;
                    end else if (bus.deq_front_req) begin
                        op <= OP_DQF;
                    end else if (bus.deq_back_req) begin
                        op <= OP_DQB;
                    end else if (bus.enq_front_req) begin
                        op      <= OP_ENF;
                        op_data <= bus.enq_front_data;
                    end else if (bus.enq_back_req) begin
                        op      <= OP_ENB;
                        op_data <= bus.enq_back_data;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    state <= ST_DONE;
                    cpl   <= 6'b1 << op;
                    err_r <= op_err;
                    if (!op_err) begin
                        case (op)
                            OP_ENB: begin
                                for (int i = 0; i < p_depth; i++)
                                    if (i == int'(count)) begin
                                        tag_mem[i]  <= free_tag;
                                        data_mem[i] <= op_data;
                                    end
                                alloc[free_tag] <= 1'b1;
                                count           <= count + cw'(1);
                                tag_b           <= free_tag;
                            end
                            OP_ENF: begin
                                for (int i = 1; i < p_depth; i++) begin
                                    tag_mem[i]  <= tag_mem[i-1];
                                    data_mem[i] <= data_mem[i-1];
                                end
                                tag_mem[0]      <= free_tag;
                                data_mem[0]     <= op_data;
                                alloc[free_tag] <= 1'b1;
                                count           <= count + cw'(1);
                                tag_f           <= free_tag;
                            end
                            OP_DQF: begin
                                dqf_data          <= data_mem[0];
                                alloc[tag_mem[0]] <= 1'b0;
                                for (int i = 0; i < p_depth - 1; i++) begin
                                    tag_mem[i]  <= tag_mem[i+1];
                                    data_mem[i] <= data_mem[i+1];
                                end
                                count <= count - cw'(1);
                            end
                            OP_DQB: begin
                                for (int i = 0; i < p_depth; i++)
                                    if (i == int'(count) - 1) begin
                                        dqb_data          <= data_mem[i];
                                        alloc[tag_mem[i]] <= 1'b0;
                                    end
                                count <= count - cw'(1);
                            end
                            OP_UPD: data_mem[match_pos] <= op_data;
                            default: begin
                                for (int i = 0; i < p_depth - 1; i++)
                                    if (i >= int'(match_pos)) begin
                                        tag_mem[i]  <= tag_mem[i+1];
                                        data_mem[i] <= data_mem[i+1];
                                    end
                                alloc[op_tag] <= 1'b0;
                                count         <= count - cw'(1);
                            end
                        endcase
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cpl   <= '0;
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.del_cpl           = cpl[OP_DEL];
    assign bus.upd_cpl           = cpl[OP_UPD];
    assign bus.deq_front_cpl     = cpl[OP_DQF];
    assign bus.deq_back_cpl      = cpl[OP_DQB];
    assign bus.enq_front_cpl     = cpl[OP_ENF];
    assign bus.enq_back_cpl      = cpl[OP_ENB];
    assign bus.err               = err_r;
    assign bus.enq_back_tag_out  = tag_b;
    assign bus.enq_front_tag_out = tag_f;
    assign bus.deq_front_data    = dqf_data;
    assign bus.deq_back_data     = dqb_data;
    assign bus.count             = count;
    assign bus.full              = is_full;
    assign bus.empty             = is_empty;

`ifdef V4_OCQ_PEEK_EN
    always_comb begin
        bus.peek_valid = alloc_pad[bus.peek_tag_in];
        bus.peek_data  = '0;
        for (int i = 0; i < p_depth; i++)
            if (bus.peek_valid && i < int'(count) && tag_mem[i] == bus.peek_tag_in)
                bus.peek_data = data_mem[i];
    end
`endif
endmodule

// File: tb/tb_v4_op_centric_queue.sv
module tb_v4_op_centric_queue;
    localparam int D  = 8;
    localparam int PW = 3;
    localparam int CH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    v4_op_centric_queue_if #(.p_depth(D), .p_ptrwidth(PW), .p_chanwidth(CH)) bus();
    v4_op_centric_queue #(.p_depth(D), .p_ptrwidth(PW), .p_chanwidth(CH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // op numbering: 0 del, 1 upd, 2 deq_front, 3 deq_back, 4 enq_front, 5 enq_back
    typedef struct { int op; bit err; logic [31:0] val; int cnt; } exp_t;
    typedef struct { logic [PW-1:0] tag; logic [31:0] data; } ent_t;

    exp_t        exp_q[$];
    ent_t        m_q[$];
    bit          m_alloc[D];
    logic [31:0] last_tb, last_tf, last_df, last_db;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        foreach (m_alloc[i]) m_alloc[i] = 1'b0;
        last_tb = 0; last_tf = 0; last_df = 0; last_db = 0;
    endtask

    task automatic model_apply(input int op, input logic [31:0] data, input logic [PW-1:0] tag,
                               output exp_t e);
        ent_t ent;
        int   idx;
        e.op  = op;
        e.err = 1'b0;
        case (op)
            4, 5: begin
                if (m_q.size() == D) e.err = 1'b1;
                else begin
                    idx = 0;
                    while (m_alloc[idx]) idx++;
                    m_alloc[idx] = 1'b1;
                    ent.tag  = PW'(idx);
                    ent.data = data;
                    if (op == 5) begin m_q.push_back(ent);  last_tb = idx; end
                    else         begin m_q.push_front(ent); last_tf = idx; end
                end
            end
            2, 3: begin
                if (m_q.size() == 0) e.err = 1'b1;
                else if (op == 2) begin
                    ent = m_q.pop_front(); m_alloc[ent.tag] = 1'b0; last_df = ent.data;
                end else begin
                    ent = m_q.pop_back();  m_alloc[ent.tag] = 1'b0; last_db = ent.data;
                end
            end
            default: begin
                idx = -1;
                foreach (m_q[i]) if (m_q[i].tag == tag) idx = i;
                if (idx < 0) e.err = 1'b1;
                else if (op == 1) m_q[idx].data = data;
                else begin
                    m_alloc[tag] = 1'b0;
                    m_q.delete(idx);
                end
            end
        endcase
        e.val = (op == 5) ? last_tb : (op == 4) ? last_tf :
                (op == 2) ? last_df : (op == 3) ? last_db : 32'h0;
        e.cnt = m_q.size();
    endtask

    task automatic set_req(input int op, input logic v);
        case (op)
            0: bus.del_req       = v;
            1: bus.upd_req       = v;
            2: bus.deq_front_req = v;
            3: bus.deq_back_req  = v;
            4: bus.enq_front_req = v;
            default: bus.enq_back_req = v;
        endcase
    endtask

    function automatic logic cpl_of(input int op);
        case (op)
            0: return bus.del_cpl;
            1: return bus.upd_cpl;
            2: return bus.deq_front_cpl;
            3: return bus.deq_back_cpl;
            4: return bus.enq_front_cpl;
            default: return bus.enq_back_cpl;
        endcase
    endfunction

    task automatic set_operands(input int op, input logic [31:0] data, input logic [PW-1:0] tag);
        case (op)
            0: bus.del_tag_in = tag;
            1: begin bus.upd_tag_in = tag; bus.upd_data_in = data; end
            4: bus.enq_front_data = data;
            5: bus.enq_back_data  = data;
            default: ;
        endcase
    endtask

    // Wait (bounded) for a cpl of op; returns number of posedges elapsed.
    task automatic wait_cpl(input int op, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!cpl_of(op) && cyc < 20);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic issue(input int op, input logic [31:0] data, input logic [PW-1:0] tag);
        exp_t e;
        int   cyc;
        model_apply(op, data, tag, e);
        exp_q.push_back(e);
        set_operands(op, data, tag);
        set_req(op, 1'b1);
        wait_cpl(op, cyc);
        set_req(op, 1'b0);
        check("latency", cyc, 2);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard monitor: every completion pops one expectation.
    always @(negedge clk) begin
        logic [5:0] c;
        exp_t       e;
        c = {bus.enq_back_cpl, bus.enq_front_cpl, bus.deq_back_cpl,
             bus.deq_front_cpl, bus.upd_cpl, bus.del_cpl};
        if (!rst) begin
            if (c != 6'b0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cpl actual=%b required=none", c);
                end else begin
                    e = exp_q.pop_front();
                    check("cpl_onehot", 32'(c), 32'(6'b1 << e.op));
                    check("err", 32'(bus.err), 32'(e.err));
                    case (e.op)
                        5: check("enq_back_tag", 32'(bus.enq_back_tag_out), e.val);
                        4: check("enq_front_tag", 32'(bus.enq_front_tag_out), e.val);
                        2: check("deq_front_data", bus.deq_front_data, e.val);
                        3: check("deq_back_data", bus.deq_back_data, e.val);
                        default: ;
                    endcase
                    check("count", 32'(bus.count), e.cnt);
                    check("full", 32'(bus.full), 32'(e.cnt == D));
                    check("empty", 32'(bus.empty), 32'(e.cnt == 0));
                end
            end else if (bus.err !== 1'b0) begin
                checks++; errors++;
                $display("FAIL err_without_cpl actual=%b required=0", bus.err);
            end
        end
    end

`ifdef V4_OCQ_PEEK_EN
    task automatic peek_check(input logic [PW-1:0] t);
        logic [31:0] exp_d;
        bit          exp_v;
        exp_v = 1'b0; exp_d = 0;
        foreach (m_q[i]) if (m_q[i].tag == t) begin exp_v = 1'b1; exp_d = m_q[i].data; end
        bus.peek_tag_in = t;
        #1;
        check("peek_valid", 32'(bus.peek_valid), 32'(exp_v));
        check("peek_data", bus.peek_data, exp_d);
    endtask
`endif

    initial begin
        exp_t e1, e2;
        int   cyc;
        int   op;
        logic [PW-1:0] t;

        bus.enq_back_req = 0; bus.enq_front_req = 0; bus.deq_front_req = 0;
        bus.deq_back_req = 0; bus.upd_req = 0; bus.del_req = 0;
        bus.enq_back_data = 0; bus.enq_front_data = 0; bus.upd_data_in = 0;
        bus.upd_tag_in = 0; bus.del_tag_in = 0;
`ifdef V4_OCQ_PEEK_EN
        bus.peek_tag_in = 0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_cpl", 32'({bus.enq_back_cpl, bus.enq_front_cpl, bus.deq_back_cpl,
                              bus.deq_front_cpl, bus.upd_cpl, bus.del_cpl}), 0);
        check("rst_tags", 32'({bus.enq_back_tag_out, bus.enq_front_tag_out}), 0);
        check("rst_dq_front", bus.deq_front_data, 0);
        check("rst_dq_back", bus.deq_back_data, 0);

        // directed sequence
        issue(5, 32'hA, 0);
        issue(5, 32'hB, 0);
        issue(5, 32'hC, 0);
        issue(4, 32'hD, 0);
        issue(2, 0, 0);
        issue(3, 0, 0);
        issue(0, 0, 3'd0);
        issue(5, 32'hE, 0);
        issue(2, 0, 0);
        issue(5, 32'hF, 0);
        issue(1, 32'h55, 3'd1);
        issue(1, 32'h77, 3'd5);
        issue(2, 0, 0);
        issue(2, 0, 0);
        issue(2, 0, 0);
        issue(3, 0, 0);
        issue(0, 0, 3'd2);
        for (int i = 0; i < D; i++) issue(5, 32'h100 + i, 0);
        issue(5, 32'hBAD, 0);
        issue(4, 32'hBAD, 0);

        // simultaneous del (higher priority) and enq_back on a full queue
        model_apply(0, 0, 3'd3, e1);
        model_apply(5, 32'h3C3C, 0, e2);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        bus.del_tag_in = 3'd3;
        bus.enq_back_data = 32'h3C3C;
        bus.del_req = 1'b1;
        bus.enq_back_req = 1'b1;
        wait_cpl(0, cyc);
        bus.del_req = 1'b0;
        check("prio_del_latency", cyc, 2);
        wait_cpl(5, cyc);
        bus.enq_back_req = 1'b0;
        check("prio_enq_gap", cyc, 3);
        @(posedge clk);
        @(negedge clk);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 5);
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                t = m_q[$urandom_range(0, m_q.size() - 1)].tag;
            else
                t = PW'($urandom_range(0, D - 1));
            issue(op, $urandom, t);
`ifdef V4_OCQ_PEEK_EN
            peek_check(PW'($urandom_range(0, D - 1)));
            if (m_q.size() > 0) peek_check(m_q[0].tag);
`endif
        end

        // reset while an enqueue is executing: no completion, queue cleared
        if (m_q.size() == D) issue(2, 0, 0);
        bus.enq_back_data = 32'hDEAD;
        bus.enq_back_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.enq_back_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_exec_count", 32'(bus.count), 0);
        check("rst_exec_empty", 32'(bus.empty), 1);
        check("rst_exec_cpl", 32'(bus.enq_back_cpl), 0);
        rst = 1'b0;
        model_reset();
        issue(5, 32'h1234, 0);
        issue(3, 0, 0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
